// File: rtl/pipe_addn_if.sv
// Handshake bundle for pipe_addn: source side (__in*) and consumer side (__out*).
// master drives the inputs of the pipe, slave is the pipe itself.
interface pipe_addn_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             __in0;
  logic [WIDTH-1:0] __in1;
  logic             __in2;
  logic             __in3;
  logic             __out0;
  logic [WIDTH-1:0] __out1;
  logic             __out2;
  logic [OCC_W-1:0] __out3;

  modport master (
    output __in0, __in1, __in2, __in3,
    input  __out0, __out1, __out2, __out3
  );

  modport slave (
    input  __in0, __in1, __in2, __in3,
    output __out0, __out1, __out2, __out3
  );
endinterface

// File: rtl/pipe_addn.sv
// DEPTH-stage add pipeline with ready/valid backpressure, bubble collapsing,
// synchronous flush, optional saturation and an occupancy count.
module pipe_addn #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 3,
  parameter int STEP_BASE = 1,
  parameter int STEP_INC  = 1,
  parameter int SATURATE  = 0
) (
  input logic        clk,
  input logic        rst,
  pipe_addn_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] d_nxt [DEPTH];
  logic [DEPTH-1:0] r;
  logic [OCC_W-1:0] occ;

  function automatic logic [WIDTH-1:0] stage_c(input int k);
    return WIDTH'(STEP_BASE + k * STEP_INC);
  endfunction

  function automatic logic [WIDTH-1:0] add_c(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] c);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, c};
    if (SATURATE != 0 && s[WIDTH]) return '1;
    return s[WIDTH-1:0];
  endfunction

  // Ready ripples from the consumer back; an empty stage is always ready,
  // which is what lets a full stage collapse into a bubble while stalled.
  always_comb begin
    logic downstream;
    downstream = bus.__in3;
    r = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      downstream = !v[k] || downstream;
      r[k] = downstream;
    end
  end

  assign d_nxt[0] = add_c(bus.__in1, stage_c(0));
  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    assign d_nxt[k] = add_c(d[k-1], stage_c(k));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r[k]) d[k] <= d_nxt[k];
      end
      if (bus.__in2) begin
        v <= '0;
      end else begin
        if (r[0]) v[0] <= bus.__in0;
        for (int k = 1; k < DEPTH; k++) begin
          if (r[k]) v[k] <= v[k-1];
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(v[k]);
  end

  assign bus.__out0 = v[DEPTH-1];
  assign bus.__out1 = v[DEPTH-1] ? d[DEPTH-1] : '0;
  assign bus.__out2 = r[0] && !bus.__in2 && rst;
  assign bus.__out3 = occ;
endmodule

// File: tb/tb_pipe_addn.sv
// Bench for pipe_addn: three instances (wrap, saturate, single stage) share one
// stimulus stream and are compared every cycle with a sample-level queue model.
module tb_pipe_addn;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_v, fl, rdy;
  logic [7:0] in_d;

  int errors = 0;
  int checks = 0;

  pipe_addn_if #(.WIDTH(8), .DEPTH(3)) if0 ();
  pipe_addn_if #(.WIDTH(8), .DEPTH(3)) if1 ();
  pipe_addn_if #(.WIDTH(8), .DEPTH(1)) if2 ();

  assign if0.__in0 = in_v; assign if0.__in1 = in_d; assign if0.__in2 = fl; assign if0.__in3 = rdy;
  assign if1.__in0 = in_v; assign if1.__in1 = in_d; assign if1.__in2 = fl; assign if1.__in3 = rdy;
  assign if2.__in0 = in_v; assign if2.__in1 = in_d; assign if2.__in2 = fl; assign if2.__in3 = rdy;

  pipe_addn #(.WIDTH(8), .DEPTH(3), .STEP_BASE(1), .STEP_INC(1), .SATURATE(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pipe_addn #(.WIDTH(8), .DEPTH(3), .STEP_BASE(1), .STEP_INC(1), .SATURATE(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pipe_addn #(.WIDTH(8), .DEPTH(1), .STEP_BASE(5), .STEP_INC(1), .SATURATE(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: samples with positions, oldest first
  function automatic int dep_of(input int id);  return (id == 2) ? 1 : 3; endfunction
  function automatic int sat_of(input int id);  return (id == 1) ? 1 : 0; endfunction
  function automatic int base_of(input int id); return (id == 2) ? 5 : 1; endfunction

  logic [7:0] mval [3][4];
  int         mpos [3][4];
  int         mcnt [3] = '{0, 0, 0};

  function automatic logic [7:0] ref_out(input int id, input logic [7:0] x);
    int acc;
    acc = int'(x);
    for (int k = 0; k < dep_of(id); k++) begin
      acc = acc + ((base_of(id) + k) % 256);
      if (sat_of(id) != 0) begin
        if (acc > 255) acc = 255;
      end else begin
        acc = acc % 256;
      end
    end
    return 8'(acc);
  endfunction

  // a sample moves unless it sits right behind an older sample that stays
  function automatic bit [3:0] model_moves(input int id, input logic ready_out);
    bit [3:0] mv;
    mv = '0;
    for (int i = 0; i < mcnt[id]; i++) begin
      if (i == 0) mv[0] = (mpos[id][0] == dep_of(id) - 1) ? ready_out : 1'b1;
      else        mv[i] = mv[i-1] || (mpos[id][i-1] != mpos[id][i] + 1);
    end
    return mv;
  endfunction

  function automatic bit model_in_ready(input int id);
    bit [3:0] mv;
    int y;
    mv = model_moves(id, rdy);
    y  = mcnt[id] - 1;
    if (!rst || fl) return 1'b0;
    if (mcnt[id] == 0) return 1'b1;
    return (mpos[id][y] != 0) || mv[y];
  endfunction

  task automatic model_commit(input int id);
    bit [3:0] mv;
    bit       take;
    int       n, np;
    take = in_v && model_in_ready(id);
    mv   = model_moves(id, rdy);
    if (fl) begin
      mcnt[id] = 0;
    end else begin
      n = 0;
      for (int i = 0; i < mcnt[id]; i++) begin
        np = mpos[id][i] + (mv[i] ? 1 : 0);
        if (np < dep_of(id)) begin
          mval[id][n] = mval[id][i];
          mpos[id][n] = np;
          n++;
        end
      end
      if (take) begin
        mval[id][n] = in_d;
        mpos[id][n] = 0;
        n++;
      end
      mcnt[id] = n;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int id = 0; id < 3; id++) mcnt[id] = 0;
    end else begin
      for (int id = 0; id < 3; id++) model_commit(id);
    end
  end

  task automatic get_act(input int id, output logic o0, output logic [7:0] o1,
                         output logic o2, output int o3);
    case (id)
      0:       begin o0 = if0.__out0; o1 = if0.__out1; o2 = if0.__out2; o3 = int'(if0.__out3); end
      1:       begin o0 = if1.__out0; o1 = if1.__out1; o2 = if1.__out2; o3 = int'(if1.__out3); end
      default: begin o0 = if2.__out0; o1 = if2.__out1; o2 = if2.__out2; o3 = int'(if2.__out3); end
    endcase
  endtask

  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      logic a0, a2, e0;
      logic [7:0] a1, e1;
      int a3;
      get_act(id, a0, a1, a2, a3);
      e0 = (mcnt[id] > 0) && (mpos[id][0] == dep_of(id) - 1);
      e1 = e0 ? ref_out(id, mval[id][0]) : 8'h00;
      check($sformatf("model%0d_out_valid", id), 32'(a0), 32'(e0));
      check($sformatf("model%0d_out_data", id),  32'(a1), 32'(e1));
      check($sformatf("model%0d_in_ready", id),  32'(a2), 32'(model_in_ready(id)));
      check($sformatf("model%0d_occupancy", id), 32'(a3), 32'(mcnt[id]));
    end
  end

  // ---------------- directed stimulus
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] e_wrap;
    logic [7:0] e_sat;
    logic [7:0] e_d1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int seen;
    tbl[0] = '{8'h10, 8'h16, 8'h16, 8'h15};
    tbl[1] = '{8'hFE, 8'h04, 8'hFF, 8'h03};
    tbl[2] = '{8'h00, 8'h06, 8'h06, 8'h05};
    tbl[3] = '{8'hFA, 8'h00, 8'hFF, 8'hFF};
    tbl[4] = '{8'hF9, 8'hFF, 8'hFF, 8'hFE};
    tbl[5] = '{8'h7F, 8'h85, 8'h85, 8'h84};

    in_v = 0; in_d = 0; fl = 0; rdy = 1;
    rst = 1;
    #1 rst = 0;
    #1;
    check("reset_out_valid", 32'(if0.__out0), 0);
    check("reset_out_data",  32'(if0.__out1), 0);
    check("reset_in_ready",  32'(if0.__out2), 0);
    check("reset_occupancy", 32'(if0.__out3), 0);
    cyc(); cyc();
    rst = 1;
    smp();
    check("empty_out_valid", 32'(if0.__out0), 0);
    check("empty_occupancy", 32'(if0.__out3), 0);
    check("empty_in_ready",  32'(if0.__out2), 1);
    check("empty_in_ready_d1", 32'(if2.__out2), 1);

    // single sample latency and per-stage arithmetic
    cyc();
    for (int i = 0; i < 6; i++) begin
      in_v = 1; in_d = tbl[i].x;
      cyc();
      in_v = 0;
      for (int s = 1; s <= 4; s++) begin
        smp();
        check($sformatf("lat%0d_s%0d_valid", i, s), 32'(if0.__out0), 32'(s == 3));
        check($sformatf("lat%0d_s%0d_wrap", i, s),  32'(if0.__out1), (s == 3) ? 32'(tbl[i].e_wrap) : 0);
        check($sformatf("lat%0d_s%0d_sat", i, s),   32'(if1.__out1), (s == 3) ? 32'(tbl[i].e_sat) : 0);
        check($sformatf("lat%0d_s%0d_occ", i, s),   32'(if0.__out3), (s <= 3) ? 1 : 0);
        check($sformatf("lat%0d_s%0d_d1", i, s),    32'(if2.__out1), (s == 1) ? 32'(tbl[i].e_d1) : 0);
        cyc();
      end
    end

    // backpressure: three accepted, fourth refused until space frees
    rdy = 0; in_v = 1; in_d = 8'h01;
    cyc(); in_d = 8'h02;
    cyc(); in_d = 8'h03;
    cyc(); in_d = 8'h04;
    smp();
    check("bp_full_in_ready", 32'(if0.__out2), 0);
    check("bp_full_occ",      32'(if0.__out3), 3);
    check("bp_full_valid",    32'(if0.__out0), 1);
    check("bp_full_data",     32'(if0.__out1), 32'h07);
    cyc();
    smp();
    check("bp_hold_data",     32'(if0.__out1), 32'h07);
    check("bp_hold_in_ready", 32'(if0.__out2), 0);
    cyc(); rdy = 1;
    smp();
    check("bp_release_in_ready", 32'(if0.__out2), 1);
    check("bp_release_data",     32'(if0.__out1), 32'h07);
    cyc(); in_v = 0;
    smp(); check("bp_out2", 32'(if0.__out1), 32'h08);
    cyc();
    smp(); check("bp_out3", 32'(if0.__out1), 32'h09);
    cyc();
    smp(); check("bp_out4", 32'(if0.__out1), 32'h0A);
    cyc();
    smp();
    check("bp_drained_valid", 32'(if0.__out0), 0);
    check("bp_drained_occ",   32'(if0.__out3), 0);
    repeat (2) cyc();

    // bubble collapse under stall
    rdy = 0; in_v = 1; in_d = 8'h00;
    cyc(); in_v = 0;
    cyc(); in_v = 1; in_d = 8'h10;
    cyc(); in_v = 0;
    cyc();
    cyc();
    smp();
    check("bubble_occ",      32'(if0.__out3), 2);
    check("bubble_in_ready", 32'(if0.__out2), 1);
    check("bubble_valid",    32'(if0.__out0), 1);
    check("bubble_out_data", 32'(if0.__out1), 32'h06);
    check("bubble_stage1",   32'(dut0.d[1]),  32'h13);
    cyc(); rdy = 1;
    repeat (5) cyc();

    // flush with a sample offered in the same cycle
    rdy = 0; in_v = 1; in_d = 8'h20;
    cyc(); in_d = 8'h21;
    cyc(); in_d = 8'h22;
    cyc(); in_d = 8'h55; fl = 1;
    smp();
    check("flush_in_ready", 32'(if0.__out2), 0);
    check("flush_occ_before", 32'(if0.__out3), 3);
    cyc(); fl = 0; in_v = 0;
    smp();
    check("flush_valid", 32'(if0.__out0), 0);
    check("flush_data",  32'(if0.__out1), 0);
    check("flush_occ",   32'(if0.__out3), 0);
    cyc(); rdy = 1;
    for (int i = 0; i < 5; i++) begin
      smp();
      check($sformatf("flush_quiet%0d", i), 32'(if0.__out0), 0);
      cyc();
    end

    // asynchronous reset with samples in flight
    rdy = 0; in_v = 1; in_d = 8'h30;
    cyc(); in_d = 8'h31;
    cyc(); in_v = 0;
    cyc();
    smp();
    check("rst_pre_valid", 32'(if0.__out0), 1);
    check("rst_pre_occ",   32'(if0.__out3), 2);
    cyc();
    #2 rst = 0;
    #1;
    check("rst_async_valid",    32'(if0.__out0), 0);
    check("rst_async_in_ready", 32'(if0.__out2), 0);
    check("rst_async_occ",      32'(if0.__out3), 0);
    cyc();
    rst = 1; rdy = 1; in_v = 1; in_d = 8'h40;
    cyc(); in_v = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (if0.__out0) begin
        seen++;
        check("rst_fresh_data", 32'(if0.__out1), 32'h46);
      end
      cyc();
    end
    check("rst_fresh_count", 32'(seen), 1);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      in_v = 1'($urandom_range(0, 1));
      in_d = 8'($urandom);
      rdy  = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 31) == 0);
      cyc();
    end
    in_v = 0; fl = 0; rdy = 1;
    repeat (6) cyc();
    smp();
    check("final_occ0", 32'(if0.__out3), 0);
    check("final_occ2", 32'(if2.__out3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
